// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Iterative RV32M multiply/divide unit for the execute stage. Multiplies run
//   a shift-add loop and divides run a restoring shift-subtract loop, one step
//   per cycle for XLEN cycles. A fix-up cycle then applies signs and selects
//   the result half. Divide-by-zero and signed overflow finish straight away.
//
// Ports
//   clk, rst      clock (rising edge) and asynchronous active-high reset
//   start         EX-stage instruction valid
//   mulsel        001 mul, 010 mulh, 011 mulhsu, 100 mulhu, 000 none
//   divsel        001 div, 010 divu, 011 rem, 100 remu, 000 none
//   a, b          rs1 / rs2 operands
//   flush         abort the operation in flight
//   busy          combinational pipeline stall request
//   done          one-cycle completion pulse
//   result        registered result, held until the next completion
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      mulsel,
  input  logic [2:0]      divsel,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t          state_q, state_d;
  logic            is_mul_q, is_mul_d;
  logic [2:0]      sel_q, sel_d;
  logic            sa_q, sa_d, sb_q, sb_d;
  logic [XLEN-1:0] opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [XLEN-1:0] hi_q, hi_d;       // product high half / partial remainder
  logic [XLEN-1:0] lo_q, lo_d;       // multiplier->product low / dividend->quotient
  logic [XLEN-1:0] result_q, result_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Accept decode. Only codes 1..4 are real operations; mul has priority.
  logic            mul_ok, div_ok, accept, acc_mul;
  logic [2:0]      acc_sel;
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf;

  assign mul_ok  = mulsel inside {3'd1, 3'd2, 3'd3, 3'd4};
  assign div_ok  = divsel inside {3'd1, 3'd2, 3'd3, 3'd4};
  assign accept  = start && !flush && (mul_ok || div_ok);
  assign acc_mul = mul_ok;
  assign acc_sel = mul_ok ? mulsel : divsel;

  // mulh: both signed; mulhsu: a signed only; div/rem: both signed.
  assign a_signed = acc_mul ? (acc_sel == 3'd2 || acc_sel == 3'd3)
                            : (acc_sel == 3'd1 || acc_sel == 3'd3);
  assign b_signed = acc_mul ? (acc_sel == 3'd2)
                            : (acc_sel == 3'd1 || acc_sel == 3'd3);
  assign a_neg = a_signed && a[XLEN-1];
  assign b_neg = b_signed && b[XLEN-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  assign div_zero = !acc_mul && (b == '0);
  assign div_ovf  = !acc_mul && a_signed && (a == MIN_NEG) && (b == '1);

  // Iteration datapath. The multiplier keeps the product in {hi,lo} and
  // shifts right; the carry out of the XLEN+1-bit add re-enters at the top.
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
  assign div_shift = {hi_q, lo_q[XLEN-1]};
  // Partial remainder is always below the divisor, so bit XLEN of the
  // difference is a clean borrow flag.
  assign div_diff  = div_shift - {1'b0, opnd_q};

  assign prod     = {hi_q, lo_q};
  assign prod_fix = (sa_q ^ sb_q) ? -prod : prod;
  assign quo_fix  = (sa_q ^ sb_q) ? -lo_q : lo_q;
  assign rem_fix  = sa_q ? -hi_q : hi_q;

  always_comb begin
    fix_result = '0;
    if (is_mul_q) begin
      fix_result = (sel_q == 3'd1) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end else begin
      fix_result = (sel_q == 3'd1 || sel_q == 3'd2) ? quo_fix : rem_fix;
    end
  end

  always_comb begin
    state_d  = state_q;
    is_mul_d = is_mul_q;
    sel_d    = sel_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          is_mul_d = acc_mul;
          sel_d    = acc_sel;
          sa_d     = a_neg;
          sb_d     = b_neg;
          cnt_d    = '0;
          hi_d     = '0;
          opnd_d   = acc_mul ? a_mag : b_mag;
          lo_d     = acc_mul ? b_mag : a_mag;
          if (div_zero) begin
            state_d  = S_DONE;
            result_d = (acc_sel == 3'd1 || acc_sel == 3'd2) ? '1 : a;
          end else if (div_ovf) begin
            state_d  = S_DONE;
            result_d = (acc_sel == 3'd1) ? MIN_NEG : '0;
          end else begin
            state_d = acc_mul ? S_MUL : S_DIV;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (state_q == S_MUL) begin
            hi_d = mul_sum[XLEN:1];
            lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
          end else if (!div_diff[XLEN]) begin
            hi_d = div_diff[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_d = div_shift[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b0};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_STEP) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          result_d = fix_result;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      is_mul_q <= 1'b0;
      sel_q    <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      is_mul_q <= is_mul_d;
      sel_q    <= sel_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Stall is dropped in DONE so the pipeline captures result that cycle.
  assign busy   = !rst && ((state_q == S_IDLE && accept) || state_q == S_MUL ||
                           state_q == S_DIV || state_q == S_FIX);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
//   Directed vectors with hand-computed results for muldiv_sequencer, plus
//   cycle-accurate busy/done timing, flush, and asynchronous reset checks.
module tb_muldiv_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  mulsel;
  logic [2:0]  divsel;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mulsel (mulsel),
    .divsel (divsel),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Launches one operation at a falling edge (cycle 0) and watches 40 cycles.
  task automatic run_op(input string tag, input logic [2:0] ms, input logic [2:0] ds,
                        input logic [31:0] aa, input logic [31:0] bb,
                        input logic [31:0] exp_res, input int exp_done_cyc);
    int busy_cnt;
    int done_cnt;
    int done_cyc;
    logic [31:0] res_at_done;
    busy_cnt = 0;
    done_cnt = 0;
    done_cyc = -1;
    res_at_done = '0;
    @(negedge clk);
    mulsel = ms; divsel = ds; a = aa; b = bb; start = 1'b1;
    #1;
    if (busy) busy_cnt++;
    @(posedge clk);
    #1;
    start = 1'b0; mulsel = 3'd0; divsel = 3'd0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        res_at_done = result;
      end
    end
    check_eq({tag, " result"}, res_at_done, exp_res);
    check_eq({tag, " done_cycle"}, 32'(done_cyc), 32'(exp_done_cyc));
    check_eq({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
    check_eq({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_done_cyc));
    check_eq({tag, " result_held"}, result, exp_res);
    $display("op %-8s a=0x%08h b=0x%08h result=0x%08h done_cycle=%0d busy_cycles=%0d",
             tag, aa, bb, res_at_done, done_cyc, busy_cnt);
  endtask

  initial begin
    int done_seen;
    rst = 1'b1; start = 1'b0; mulsel = 3'd0; divsel = 3'd0;
    a = '0; b = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset busy", 32'(busy), 32'd0);
    check_eq("reset done", 32'(done), 32'd0);
    check_eq("reset result", result, 32'd0);
    rst = 1'b0;

    run_op("mul",    3'd1, 3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
    run_op("mulh",   3'd2, 3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 34);
    run_op("mulhu",  3'd4, 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
    run_op("mulhsu", 3'd3, 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
    run_op("div",    3'd0, 3'd1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
    run_op("rem",    3'd0, 3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
    run_op("divu",   3'd0, 3'd2, 32'd100,      32'd7,        32'd14,       34);
    run_op("remu",   3'd0, 3'd4, 32'd100,      32'd7,        32'd2,        34);
    run_op("div0",   3'd0, 3'd1, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("rem0",   3'd0, 3'd3, 32'd5,        32'd0,        32'd5,        1);
    run_op("divovf", 3'd0, 3'd1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("removf", 3'd0, 3'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);
    run_op("mulsmall", 3'd1, 3'd0, 32'd3,      32'd5,        32'd15,       34);

    // Flush a div during its cycle 10.
    done_seen = 0;
    @(negedge clk);
    divsel = 3'd2; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; divsel = 3'd0;
    for (int cyc = 1; cyc < 10; cyc++) begin
      @(negedge clk);
      if (done) done_seen++;
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(negedge clk);
    check_eq("flush busy_in_cycle10", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    #2;
    check_eq("flush busy_after", 32'(busy), 32'd0);
    check_eq("flush no_done", 32'(done_seen + int'(done)), 32'd0);
    check_eq("flush result_kept", result, 32'd15);
    $display("op flush    div aborted in cycle 10, result=0x%08h", result);
    run_op("mulpost", 3'd1, 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34);

    // Asynchronous reset in cycle 15 of a mul.
    @(negedge clk);
    mulsel = 3'd1; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; mulsel = 3'd0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    check_eq("rst pre busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("rst async busy", 32'(busy), 32'd0);
    check_eq("rst async done", 32'(done), 32'd0);
    check_eq("rst async result", result, 32'd0);
    mulsel = 3'd1; start = 1'b1;
    #1;
    check_eq("rst forces busy low", 32'(busy), 32'd0);
    start = 1'b0; mulsel = 3'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    $display("op reset   asserted mid-mul, result=0x%08h", result);

    @(negedge clk);
    start = 1'b1; mulsel = 3'd0; divsel = 3'd0;
    #1;
    check_eq("none busy", 32'(busy), 32'd0);
    @(negedge clk);
    check_eq("none still_idle", 32'(busy), 32'd0);
    mulsel = 3'd5;
    #1;
    check_eq("badcode busy", 32'(busy), 32'd0);
    @(negedge clk);
    check_eq("badcode done", 32'(done), 32'd0);
    start = 1'b0; mulsel = 3'd0;
    $display("op nosel   start without valid select not accepted");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
